// File: rtl/dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dm_arbiter                                                     |
// | Purpose  : Two-requester data-memory sequencer/arbiter; partial stores    |
// |            become read-modify-write. Define DM_ARB_FIXED_PRIO_EN for      |
// |            fixed m0 priority instead of round-robin.                      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module dm_arbiter #(
    parameter int ADDR_W  = 10,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout,
    output logic              busy
);
    localparam int c_WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RMW  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_id;
    logic               r_we;
    logic [c_WA_W-1:0]  r_waddr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [31:0]        r_merge;
    logic [31:0]        r_rdata0;
    logic [31:0]        r_rdata1;
    logic               w_grant;
    logic               w_gid;
    logic               w_full;
    logic               w_partial;
    logic [31:0]        w_merged;
    logic               w_unused;

    assign w_unused = &{1'b0, m0_addr[1:0], m1_addr[1:0], RR_INIT};
    assign w_grant  = m0_req | m1_req;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign w_gid = ~m0_req;
`else
    logic r_ptr;

    assign w_gid = (m0_req && m1_req) ? r_ptr : ~m0_req;

    // Pointer only moves on contention, handing priority to the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= RR_INIT;
        end else if (r_state == S_IDLE && m0_req && m1_req) begin
            r_ptr <= ~w_gid;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_full    = (r_be == 4'hF);
    assign w_partial = r_we && !w_full && (r_be != 4'h0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ACC;
            S_ACC:   w_next = w_partial ? S_RMW : S_RESP;
            S_RMW:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id    <= w_gid;
                        r_we    <= w_gid ? m1_we : m0_we;
                        r_waddr <= w_gid ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
                        r_be    <= w_gid ? m1_be : m0_be;
                        r_wdata <= w_gid ? m1_wdata : m0_wdata;
                    end
                end
                S_ACC: begin
                    if (!r_we) begin
                        if (r_id) r_rdata1 <= dm_dout;
                        else      r_rdata0 <= dm_dout;
                    end else if (w_partial) begin
                        r_merge <= dm_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_merged = r_merge;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    // Writes are masked by rst so an abort never lands on the reset edge.
    always_comb begin
        dm_we  = 1'b0;
        dm_din = 32'h0;
        if (r_state == S_ACC && r_we && w_full) begin
            dm_we  = ~rst;
            dm_din = r_wdata;
        end else if (r_state == S_RMW) begin
            dm_we  = ~rst;
            dm_din = w_merged;
        end
    end

    assign dm_addr  = {r_waddr, 2'b00};
    assign m0_ack   = (r_state == S_RESP) && !r_id;
    assign m1_ack   = (r_state == S_RESP) && r_id;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
